// File: rtl/scanner_link_if.sv
// scanner_link_if: request handshake and serial-line signals of the scanner link transmitter.
// master = request source / line observer, slave = the transmitter.
interface scanner_link_if;
    logic       req_valid;
    logic [1:0] req_kind;
    logic [7:0] req_byte;
    logic       req_ready;
    logic       ser_out;
    logic       frame_start;
    logic       busy;
    logic       err;

    modport master (
        output req_valid,
        output req_kind,
        output req_byte,
        input  req_ready,
        input  ser_out,
        input  frame_start,
        input  busy,
        input  err
    );

    modport slave (
        input  req_valid,
        input  req_kind,
        input  req_byte,
        output req_ready,
        output ser_out,
        output frame_start,
        output busy,
        output err
    );
endinterface

// File: rtl/scanner_link_tx.sv
// scanner_link_tx: continuous 8-bit MSB-first frame transmitter for the scanner link.
// A one-entry holding register takes status commands (one frame) and data
// transfers (header frame 0x07/0x08 followed by the payload frame).
// Idle frames are 0x00.
// Optional build: define SCANNER_TX_STATS_EN to add the 16-bit saturating
// sent_cnt output counting completed command and payload frames.
//
// state | meaning (frame currently on the wire)
// IDLE  | filler 0x00 frame
// CMD   | status command code frame
// HDR   | data header frame (0x07 binary, 0x08 ASCII); payload follows
// DATA  | payload byte of a data transfer
module scanner_link_tx (
    input  logic          clk,
    input  logic          rst,
    scanner_link_if.slave link
`ifdef SCANNER_TX_STATS_EN
    ,
    output logic [15:0]   sent_cnt
`endif
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_HDR  = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    localparam logic [1:0] KIND_CMD  = 2'b00;
    localparam logic [1:0] KIND_BIN  = 2'b01;
    localparam logic [1:0] KIND_ASC  = 2'b10;
    localparam logic [7:0] HDR_BIN   = 8'h07;
    localparam logic [7:0] HDR_ASC   = 8'h08;
    localparam logic [7:0] IDLE_BYTE = 8'h00;
    localparam logic [7:0] CODE_MAX  = 8'd6;

    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    state_t     state;
    state_t     state_nxt;
    logic       pending;
    logic [1:0] held_kind;
    logic [7:0] held_byte;
    logic       err_q;

    logic       boundary;
    logic       accept;
    logic       req_legal;
    logic       pend_clr;
    logic [7:0] frame_byte;

    // The last bit of every frame is on the wire when bit_cnt is 7; the edge
    // that ends it loads the next frame.
    assign boundary = (bit_cnt == 3'd7);

    // The handshake only needs the holding register to be empty; rst wins in
    // every register below, so a request offered during reset is ignored.
    assign accept = link.req_valid && !pending;

    // Legality of an offered request: status codes 1..6 only, kind 11 never.
    always_comb begin
        req_legal = 1'b0;
        case (link.req_kind)
            KIND_CMD: req_legal = (link.req_byte != 8'd0) && (link.req_byte <= CODE_MAX);
            KIND_BIN: req_legal = 1'b1;
            KIND_ASC: req_legal = 1'b1;
            default:  req_legal = 1'b0;
        endcase
    end

    // Free-running bit position within the current frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= 3'd0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next frame selection; decisions only happen on a frame boundary and use
    // the holding register as it was before that edge, so a request accepted
    // on the boundary edge itself waits for the following boundary.
    always_comb begin
        state_nxt  = state;
        frame_byte = IDLE_BYTE;
        pend_clr   = 1'b0;
        if (boundary) begin
            if (state == ST_HDR) begin
                frame_byte = held_byte;
                state_nxt  = ST_DATA;
                pend_clr   = 1'b1;
            end else if (pending) begin
                case (held_kind)
                    KIND_CMD: begin
                        frame_byte = held_byte;
                        state_nxt  = ST_CMD;
                        pend_clr   = 1'b1;
                    end
                    KIND_BIN: begin
                        frame_byte = HDR_BIN;
                        state_nxt  = ST_HDR;
                    end
                    KIND_ASC: begin
                        frame_byte = HDR_ASC;
                        state_nxt  = ST_HDR;
                    end
                    default: begin
                        // Illegal kinds never reach the holding register.
                        frame_byte = IDLE_BYTE;
                        state_nxt  = ST_IDLE;
                        pend_clr   = 1'b1;
                    end
                endcase
            end else begin
                frame_byte = IDLE_BYTE;
                state_nxt  = ST_IDLE;
            end
        end
    end

    // Shift register: load the selected frame at a boundary, otherwise shift
    // MSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= IDLE_BYTE;
        end else if (boundary) begin
            shift_reg <= frame_byte;
        end else begin
            shift_reg <= {shift_reg[6:0], 1'b0};
        end
    end

    // Holding register: filled by a legal accept, emptied when the last frame
    // of its transfer is loaded. Accept requires it empty and clearing requires
    // it full, so the two never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= 1'b0;
            held_kind <= KIND_CMD;
            held_byte <= 8'h00;
        end else if (accept && req_legal) begin
            pending   <= 1'b1;
            held_kind <= link.req_kind;
            held_byte <= link.req_byte;
        end else if (pend_clr) begin
            pending   <= 1'b0;
        end
    end

    // Illegal request flag, one cycle after the dropping accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && !req_legal;
        end
    end

    assign link.req_ready   = !pending;
    assign link.ser_out     = shift_reg[7];
    assign link.frame_start = (bit_cnt == 3'd0);
    assign link.busy        = pending || (state != ST_IDLE);
    assign link.err         = err_q;

`ifdef SCANNER_TX_STATS_EN
    logic [15:0] sent_cnt_q;

    // Count command and payload frames as they finish; headers are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            sent_cnt_q <= 16'd0;
        end else if (boundary && (state == ST_CMD || state == ST_DATA) &&
                     sent_cnt_q != 16'hFFFF) begin
            sent_cnt_q <= sent_cnt_q + 16'd1;
        end
    end

    assign sent_cnt = sent_cnt_q;
`endif

    // A header frame always has its payload still held, and is always
    // followed directly by the payload frame.
    a_hdr_holds: assert property (@(posedge clk) disable iff (rst)
        state == ST_HDR |-> pending);
    a_hdr_then_data: assert property (@(posedge clk) disable iff (rst)
        (boundary && state == ST_HDR) |=> state == ST_DATA);

endmodule

// File: tb/tb_scanner_link_tx.sv
// tb_scanner_link_tx: vector table, directed sequences and random traffic,
// all compared every cycle against a frame-level reference model.
module tb_scanner_link_tx;
    logic clk = 1'b0;
    logic rst;
    scanner_link_if link ();

`ifdef SCANNER_TX_STATS_EN
    logic [15:0] sent_cnt;
`endif

    scanner_link_tx dut (
        .clk  (clk),
        .rst  (rst),
        .link (link)
`ifdef SCANNER_TX_STATS_EN
        ,
        .sent_cnt (sent_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a transfer is the list of frame bytes still to send.
    logic [7:0] m_q[$];     // bytes of the held transfer not yet on the wire
    bit         m_qc[$];    // whether each of those frames is counted
    logic [7:0] m_frame;    // byte on the wire now
    bit         m_active;   // frame on the wire belongs to a transfer
    bit         m_counted;  // frame on the wire is a command or payload
    int         m_t;        // cycles since reset
    bit         m_err;
    logic [15:0] m_sent;

    typedef struct {
        logic [1:0] kind;
        logic [7:0] byt;
        logic       exp_err;
        logic [7:0] exp_f0;
        logic [7:0] exp_f1;
    } vec_t;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] k, input logic [7:0] b);
        link.req_valid = v;
        link.req_kind  = k;
        link.req_byte  = b;
    endtask

    // One clock: advance the model with the inputs presented, then compare at negedge.
    task automatic step();
        bit         acc;
        logic [1:0] k;
        logic [7:0] b;
        int         idx;
        acc = link.req_valid && (m_q.size() == 0) && !rst;
        k   = link.req_kind;
        b   = link.req_byte;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_qc.delete();
            m_frame   = 8'h00;
            m_active  = 0;
            m_counted = 0;
            m_t       = 0;
            m_err     = 0;
            m_sent    = 16'd0;
        end else begin
            if (m_t % 8 == 7) begin
                if (m_counted && m_sent != 16'hFFFF) m_sent = m_sent + 16'd1;
                if (m_q.size() > 0) begin
                    m_frame   = m_q.pop_front();
                    m_counted = m_qc.pop_front();
                    m_active  = 1;
                end else begin
                    m_frame   = 8'h00;
                    m_counted = 0;
                    m_active  = 0;
                end
            end
            m_t++;
            m_err = 0;
            if (acc) begin
                if (k == 2'b00 && b >= 8'd1 && b <= 8'd6) begin
                    m_q.push_back(b);      m_qc.push_back(1);
                end else if (k == 2'b01) begin
                    m_q.push_back(8'h07);  m_qc.push_back(0);
                    m_q.push_back(b);      m_qc.push_back(1);
                end else if (k == 2'b10) begin
                    m_q.push_back(8'h08);  m_qc.push_back(0);
                    m_q.push_back(b);      m_qc.push_back(1);
                end else begin
                    m_err = 1;
                end
            end
        end
        @(negedge clk);
        idx = 7 - (m_t % 8);
        chk("ser_out",     16'(link.ser_out),     16'(m_frame[idx]));
        chk("frame_start", 16'(link.frame_start), 16'(m_t % 8 == 0));
        chk("req_ready",   16'(link.req_ready),   16'(m_q.size() == 0));
        chk("busy",        16'(link.busy),        16'((m_q.size() != 0) || m_active));
        chk("err",         16'(link.err),         16'(m_err));
`ifdef SCANNER_TX_STATS_EN
        chk("sent_cnt",    sent_cnt,              m_sent);
`endif
    endtask

    // Collect the next whole frame from the wire; ends on its last bit.
    task automatic expect_frame(input string name, input logic [7:0] exp);
        int         n;
        logic [7:0] got;
        n = 0;
        while (!link.frame_start && n < 16) begin
            step();
            n++;
        end
        chk({name, "_start"}, 16'(link.frame_start), 16'd1);
        if (!link.frame_start) return;
        got[7] = link.ser_out;
        for (int i = 6; i >= 0; i--) begin
            step();
            got[i] = link.ser_out;
        end
        chk(name, 16'(got), 16'(exp));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{2'b00, 8'h00, 1'b1, 8'h00, 8'h00};
        vecs[1] = '{2'b00, 8'h01, 1'b0, 8'h01, 8'h00};
        vecs[2] = '{2'b00, 8'h06, 1'b0, 8'h06, 8'h00};
        vecs[3] = '{2'b00, 8'h07, 1'b1, 8'h00, 8'h00};
        vecs[4] = '{2'b00, 8'hFF, 1'b1, 8'h00, 8'h00};
        vecs[5] = '{2'b01, 8'h00, 1'b0, 8'h07, 8'h00};
        vecs[6] = '{2'b01, 8'h08, 1'b0, 8'h07, 8'h08};
        vecs[7] = '{2'b10, 8'h41, 1'b0, 8'h08, 8'h41};
        vecs[8] = '{2'b10, 8'h07, 1'b0, 8'h08, 8'h07};
        vecs[9] = '{2'b11, 8'h03, 1'b1, 8'h00, 8'h00};

        drive(1'b0, 2'b00, 8'h00);
        rst = 1'b1;
        do_reset();

        // Reset state, then 24 idle cycles.
        chk("rst_ser_out",     16'(link.ser_out),     16'd0);
        chk("rst_frame_start", 16'(link.frame_start), 16'd1);
        chk("rst_req_ready",   16'(link.req_ready),   16'd1);
        chk("rst_busy",        16'(link.busy),        16'd0);
        chk("rst_err",         16'(link.err),         16'd0);
        for (int c = 0; c < 24; c++) begin
            chk("idle_ser_out", 16'(link.ser_out),     16'd0);
            chk("idle_fs",      16'(link.frame_start), 16'(c % 8 == 0));
            step();
        end

        // Command 0x03 accepted at bit_cnt 2.
        step();
        step();
        drive(1'b1, 2'b00, 8'h03);
        step();
        drive(1'b0, 2'b00, 8'h00);
        chk("cmd_busy_held", 16'(link.busy), 16'd1);
        expect_frame("cmd03_frame", 8'h03);
        step();
        chk("cmd03_busy_after", 16'(link.busy), 16'd0);
        expect_frame("cmd03_idle", 8'h00);

        // Binary 0xA5 accepted on a boundary edge: one idle frame first.
        drive(1'b1, 2'b01, 8'hA5);
        step();
        drive(1'b0, 2'b00, 8'h00);
        expect_frame("bin_wait_idle", 8'h00);
        expect_frame("bin_hdr", 8'h07);
        chk("bin_ready_in_hdr", 16'(link.req_ready), 16'd0);
        expect_frame("bin_payload", 8'hA5);
        chk("bin_ready_in_data", 16'(link.req_ready), 16'd1);

        // Two illegal requests back to back.
        step();
        drive(1'b1, 2'b00, 8'h07);
        step();
        chk("ill_cmd07_err", 16'(link.err), 16'd1);
        drive(1'b1, 2'b11, 8'h02);
        step();
        chk("ill_kind3_err", 16'(link.err), 16'd1);
        drive(1'b0, 2'b00, 8'h00);
        step();
        chk("ill_err_clear", 16'(link.err), 16'd0);
        expect_frame("ill_idle0", 8'h00);
        expect_frame("ill_idle1", 8'h00);

        // Vector table: each request offered early in a frame.
        foreach (vecs[i]) begin
            step();
            drive(1'b1, vecs[i].kind, vecs[i].byt);
            step();
            drive(1'b0, 2'b00, 8'h00);
            chk($sformatf("vec%0d_err", i), 16'(link.err), 16'(vecs[i].exp_err));
            expect_frame($sformatf("vec%0d_f0", i), vecs[i].exp_f0);
            expect_frame($sformatf("vec%0d_f1", i), vecs[i].exp_f1);
        end

        // ASCII 0x41 aborted by reset during its header; request offered in reset ignored.
        step();
        drive(1'b1, 2'b10, 8'h41);
        step();
        drive(1'b0, 2'b00, 8'h00);
        for (int n = 0; n < 16 && !link.frame_start; n++) step();
        chk("abort_hdr_busy", 16'(link.busy), 16'd1);
        step();
        step();
        step();
        rst = 1'b1;
        drive(1'b1, 2'b00, 8'h02);
        step();
        rst = 1'b0;
        drive(1'b0, 2'b00, 8'h00);
        chk("abort_fs",    16'(link.frame_start), 16'd1);
        chk("abort_ready", 16'(link.req_ready),   16'd1);
        chk("abort_busy",  16'(link.busy),        16'd0);
        expect_frame("abort_f0", 8'h00);
        expect_frame("abort_f1", 8'h00);
        expect_frame("abort_f2", 8'h00);

`ifdef SCANNER_TX_STATS_EN
        do_reset();
        drive(1'b1, 2'b00, 8'h05);
        step();
        drive(1'b1, 2'b10, 8'h33);
        for (int n = 0; n < 32 && !link.req_ready; n++) step();
        step();
        drive(1'b0, 2'b00, 8'h00);
        for (int n = 0; n < 40 && link.busy; n++) step();
        chk("stats_two", sent_cnt, 16'd2);
        force dut.sent_cnt_q = 16'hFFFF;
        m_sent = 16'hFFFF;
        step();
        release dut.sent_cnt_q;
        drive(1'b1, 2'b00, 8'h01);
        step();
        drive(1'b0, 2'b00, 8'h00);
        for (int n = 0; n < 40 && link.busy; n++) step();
        step();
        chk("stats_sat", sent_cnt, 16'hFFFF);
`endif

        // Random traffic with occasional resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            drive(($urandom_range(0, 2) != 0),
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 9)) : 8'($urandom));
            step();
        end
        rst = 1'b0;
        drive(1'b0, 2'b00, 8'h00);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/scanner_link_tx.md
SCANNER_LINK_TX -- requirements
Module: scanner_link_tx

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock for all logic.
REQ-002 SHALL: rst  input  1  reset, synchronous, active-high; clock clk.
REQ-003 SHALL: req_valid  input  1  request offered this cycle.
REQ-004 SHALL: req_kind  input  2  request kind: 00 status command, 01 binary data, 10 ASCII data, 11 illegal.
REQ-005 SHALL: req_byte  input  8  status code (kind 00) or payload byte (kinds 01/10).
REQ-006 SHALL: req_ready  output  1  holding register empty; request accepted on edge with req_valid && req_ready.
REQ-007 SHALL: ser_out  output  1  serial line, one bit per clk, MSB first, continuous 8-bit frames.
REQ-008 SHALL: frame_start  output  1  high in the cycle ser_out carries bit 7 of a frame (bit_cnt == 0).
REQ-009 SHALL: busy  output  1  high while a request is held or a non-idle frame is on the wire.
REQ-010 SHALL: err  output  1  one-cycle pulse when an accepted request is dropped as illegal.

Function
REQ-011 SHALL: 3-bit bit_cnt increment every cycle, wrapping 7->0; frame boundary is the edge at which bit_cnt == 7.
REQ-012 SHALL: 8-bit shift register shift left by one each edge except at a frame boundary, where it loads the next frame byte; ser_out = shift_reg[7].
REQ-013 SHALL: one-entry holding register (pending); req_ready = !pending; accept loads req_kind/req_byte and sets pending.
REQ-014 SHALL: a request accepted on a frame-boundary edge not be transmitted until the following boundary.
REQ-015 SHALL: FSM states, reflecting the frame on the wire: IDLE (0x00), CMD, HDR, DATA.
REQ-016 SHALL: at a boundary from IDLE, CMD or DATA: pending kind 00 -> load req_byte, go CMD, clear pending; kind 01 -> load 0x07, go HDR; kind 10 -> load 0x08, go HDR; nothing pending -> load 0x00, go IDLE.
REQ-017 SHALL: at a boundary from HDR, load the held payload byte, go DATA, clear pending; a data transfer is always exactly two back-to-back frames.
REQ-018 SHALL: status codes legal only in range 1..6; kind 00 with req_byte 0 or >6, or any kind 11, be dropped at acceptance (pending not set), with err pulsed the next cycle.
REQ-019 SHALL: payload bytes of any value (including 0x00-0x08) be sent unaltered in the DATA frame.
REQ-020 SHALL: busy = pending || state != IDLE.
REQ-021 SHALL: back-to-back requests produce back-to-back frames with no idle frame if each request is accepted before the boundary at which it is needed.

Reset
REQ-022 SHALL: on rst: bit_cnt=0, shift_reg=0x00, state=IDLE, pending=0; outputs ser_out=0, frame_start=1, req_ready=1, busy=0, err=0 in the cycle after.
REQ-023 SHALL: rst mid-frame or mid-transfer abort everything; held request discarded; first post-reset frame is 0x00 aligned to bit_cnt=0.
REQ-024 SHALL: req_valid be ignored in any cycle rst is high.

Configuration
REQ-025 SHALL: macro SCANNER_TX_STATS_EN, when defined, add output sent_cnt (16 bits) incrementing once per completed CMD or DATA frame, saturating at 0xFFFF, reset to 0.
REQ-026 SHALL: without SCANNER_TX_STATS_EN, no sent_cnt port or counter exist; all other behaviour identical.

Verification
REQ-027 SHALL: reset, no requests for 24 cycles -> ser_out constant 0, frame_start high on cycles 0, 8, 16.
REQ-028 SHALL: kind 00 byte 0x03 accepted at bit_cnt 2 -> next frame on wire is bits 0,0,0,0,0,0,1,1, then 0x00; busy falls after that frame.
REQ-029 SHALL: kind 01 byte 0xA5 -> frames 0x07 then 0xA5 back-to-back; req_ready low until the 0xA5 load edge.
REQ-030 SHALL: kind 00 byte 0x07, then kind 11 -> each dropped, err pulses once per request, ser_out stays 0x00 frames.
REQ-031 SHALL: kind 10 byte 0x41 with rst asserted during the 0x08 header frame -> line returns to 0x00 frames aligned to reset, 0x41 never sent.
REQ-032 SHALL: with SCANNER_TX_STATS_EN, send 1 command + 1 ASCII transfer -> sent_cnt = 2 after completion (header frame not counted); forced 0xFFFF stays 0xFFFF.
